// File: rtl/adder_driver_pkg.sv
// Shared types and constants for the adder driver slice.
package pa_adder;

    localparam int A_W = 4;
    localparam int C_W = 7;

    // Reset value of the captured sum; above the largest real sum (30),
    // so a response register that never captured anything stands out.
    localparam logic [C_W-1:0] RV_C = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESPOND
    } adder_drv_state_e;

    // Reference sum of two operands, zero-extended to the sum width.
    function automatic logic [C_W-1:0] ref_sum(input logic [A_W-1:0] a,
                                               input logic [A_W-1:0] b);
        return {{(C_W-A_W){1'b0}}, a} + {{(C_W-A_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/adder_driver_if.sv
// Command, adder and response buses of the adder driver.
interface adder_driver_if #(parameter int TAG_W = 4) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [pa_adder::A_W-1:0]   in_a;
    logic [pa_adder::A_W-1:0]   in_b;
    logic [TAG_W-1:0]           in_tag;

    logic                       add_valid;
    logic [pa_adder::A_W-1:0]   add_a;
    logic [pa_adder::A_W-1:0]   add_b;
    logic [pa_adder::C_W-1:0]   add_c;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [pa_adder::C_W-1:0]   rsp_c;
    logic [TAG_W-1:0]           rsp_tag;
    logic                       rsp_err;
    logic [7:0]                 err_cnt;

    // Driver side.
    modport slave (
        input  in_valid, in_a, in_b, in_tag, add_c, rsp_ready,
        output in_ready, add_valid, add_a, add_b,
               rsp_valid, rsp_c, rsp_tag, rsp_err, err_cnt
    );

    // Control logic / adder side.
    modport master (
        output in_valid, in_a, in_b, in_tag, add_c, rsp_ready,
        input  in_ready, add_valid, add_a, add_b,
               rsp_valid, rsp_c, rsp_tag, rsp_err, err_cnt
    );

endinterface

// File: rtl/adder_driver_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module adder_drv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers; cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/adder_driver.sv
// Initiator-side driver for the adder: buffers commands, issues one
// operation at a time, checks the returned sum and reports it in order.
module adder_driver
    import pa_adder::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    adder_driver_if.slave bus
);

    localparam int ENT_W = 2 * A_W + TAG_W;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_din;
    logic [ENT_W-1:0] fifo_head;

    logic [A_W-1:0]   head_a;
    logic [A_W-1:0]   head_b;
    logic [TAG_W-1:0] head_tag;

    adder_drv_state_e state_q;
    logic             add_valid_q;
    logic [A_W-1:0]   add_a_q;
    logic [A_W-1:0]   add_b_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             rsp_valid_q;
    logic [C_W-1:0]   rsp_c_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_err_q;
    logic [7:0]       err_cnt_q;

    logic             rsp_hs;
    logic             start_issue;

    assign fifo_push = bus.in_valid && !fifo_full;
    assign fifo_pop  = (state_q == ST_ISSUE);
    assign fifo_din  = {bus.in_a, bus.in_b, bus.in_tag};

    assign head_a   = fifo_head[ENT_W-1 -: A_W];
    assign head_b   = fifo_head[TAG_W +: A_W];
    assign head_tag = fifo_head[TAG_W-1:0];

    adder_drv_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_hs = (state_q == ST_RESPOND) && bus.rsp_ready;

    // A new operation starts from IDLE, or straight out of a completed
    // response, whenever the FIFO holds a command.
    always_comb begin
        start_issue = !fifo_empty &&
                      ((state_q == ST_IDLE) || rsp_hs);
    end

    // Operation sequencer with registered adder and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            op_tag_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= RV_C;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_ISSUE: begin
                    add_valid_q <= 1'b0;
                    state_q     <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rsp_c_q     <= bus.add_c;
                    rsp_err_q   <= (bus.add_c != ref_sum(add_a_q, add_b_q));
                    rsp_tag_q   <= op_tag_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // The issue pulse and operand latch override the holds above.
            if (start_issue) begin
                state_q     <= ST_ISSUE;
                add_valid_q <= 1'b1;
                add_a_q     <= head_a;
                add_b_q     <= head_b;
                op_tag_q    <= head_tag;
            end
        end
    end

    // Saturating count of responses delivered with an error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (rsp_hs && rsp_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.add_valid = add_valid_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
